// File: rtl/nfc_pkg.sv
// -----------------------------------------------------------------------------
// nfc_pkg
// Shared definitions for the NFC command scheduler: command width, the
// command field positions (same layout the NFC itself decodes) and the
// scheduler state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package nfc_pkg;

    localparam int CMD_W = 33;

    // Command field positions
    localparam int CMD_RW                  = 32;
    localparam int CMD_FLASH_ADDR_HI       = 31;
    localparam int CMD_FLASH_ADDR_LO       = 14;
    localparam int CMD_FLASH_BLOCK_ADDR_HI = 31;
    localparam int CMD_FLASH_BLOCK_ADDR_LO = 25;
    localparam int CMD_MEM_ADDR_HI         = 13;
    localparam int CMD_MEM_ADDR_LO         = 7;
    localparam int CMD_RW_LEN_HI           = 6;
    localparam int CMD_RW_LEN_LO           = 0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } sched_state_t;

endpackage

// File: rtl/nfc_cmd_sched_if.sv
// -----------------------------------------------------------------------------
// nfc_cmd_sched_if
// Bundles the requester-side handshake and the NFC cmd/done interface of the
// command scheduler.
//   req_valid/req_cmd/req_ready : per-requester command handshake
//   rsp_done/rsp_err            : per-requester completion pulses
//   nfc_cmd/nfc_start/nfc_done  : command to, and completion toggle from, NFC
//   busy                        : scheduler has a command in flight
// Modports: master = requesters + NFC side, slave = the scheduler.
// -----------------------------------------------------------------------------
interface nfc_cmd_sched_if #(
    parameter int N_REQ = 4
);
    import nfc_pkg::*;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*CMD_W-1:0] req_cmd;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_done;
    logic [N_REQ-1:0]       rsp_err;
    logic [CMD_W-1:0]       nfc_cmd;
    logic                   nfc_start;
    logic                   nfc_done;
    logic                   busy;

    modport master (
        output req_valid, req_cmd, nfc_done,
        input  req_ready, rsp_done, rsp_err, nfc_cmd, nfc_start, busy
    );

    modport slave (
        input  req_valid, req_cmd, nfc_done,
        output req_ready, rsp_done, rsp_err, nfc_cmd, nfc_start, busy
    );

endinterface

// File: rtl/nfc_rr_arb.sv
// -----------------------------------------------------------------------------
// nfc_rr_arb
// Purely combinational round-robin arbiter. Picks the first asserted request
// at or above ptr, wrapping at N_REQ-1 (works for non-power-of-2 N_REQ).
//   req     : request vector
//   ptr     : search start index (0..N_REQ-1)
//   gnt     : one-hot grant, 0 when no request
//   gnt_idx : binary index of the granted request, 0 when no request
// -----------------------------------------------------------------------------
module nfc_rr_arb #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] idx;
    logic             found;

    // NOTE: every variable gets a default before the loop so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
            idx = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/nfc_cmd_sched.sv
// -----------------------------------------------------------------------------
// nfc_cmd_sched
// Round-robin command scheduler in front of the NAND flash controller. One
// command is outstanding at a time; completion is any transition of nfc_done.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : nfc_cmd_sched_if.slave (requester handshake, responses, NFC side)
// Optional build macro NFC_TIMEOUT_EN: adds a BUSY watchdog of TIMEOUT_CYC
// cycles that completes the command with rsp_err; otherwise rsp_err is 0.
// -----------------------------------------------------------------------------
module nfc_cmd_sched
    import nfc_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    nfc_cmd_sched_if.slave   bus
);
    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("nfc_cmd_sched: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("nfc_cmd_sched: TIMEOUT_CYC must be at least 1");
    end

    sched_state_t     state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] rsp_done_q;
    logic [CMD_W-1:0] nfc_cmd_q;
    logic [CMD_W-1:0] sel_cmd;
    logic             nfc_start_q;
    logic             busy_q;
    logic             done_q;
    logic             done_edge;
    logic             accept;

    nfc_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign accept    = (state == IDLE) && (|gnt);
    assign sel_cmd   = bus.req_cmd[CMD_W*gnt_idx +: CMD_W];
    assign owner_oh  = N_REQ'(1) << owner;
    // Either polarity of nfc_done change is one completion.
    assign done_edge = bus.nfc_done ^ done_q;

`ifdef NFC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0]  wd_cnt;
    logic [N_REQ-1:0] rsp_err_q;
    logic             wd_expire;

    // Fires on the BUSY cycle whose increment would reach TIMEOUT_CYC, so
    // RESP lands TIMEOUT_CYC+1 cycles after nfc_start.
    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            nfc_cmd_q   <= '0;
            nfc_start_q <= 1'b0;
            rsp_done_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef NFC_TIMEOUT_EN
            wd_cnt      <= '0;
            rsp_err_q   <= '0;
`endif
        end else begin
            // Edges arriving outside BUSY are absorbed here and never answered.
            done_q      <= bus.nfc_done;
            nfc_start_q <= 1'b0;
            rsp_done_q  <= '0;
`ifdef NFC_TIMEOUT_EN
            rsp_err_q   <= '0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        nfc_cmd_q   <= sel_cmd;
                        owner       <= gnt_idx;
                        nfc_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef NFC_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= BUSY;
                end
                BUSY: begin
                    if (done_edge) begin
                        rsp_done_q <= owner_oh;
                        state      <= RESP;
                    end
`ifdef NFC_TIMEOUT_EN
                    else if (wd_expire) begin
                        rsp_done_q <= owner_oh;
                        rsp_err_q  <= owner_oh;
                        state      <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    rr_ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE) ? gnt : '0;
    assign bus.rsp_done  = rsp_done_q;
    assign bus.nfc_cmd   = nfc_cmd_q;
    assign bus.nfc_start = nfc_start_q;
    assign bus.busy      = busy_q;
`ifdef NFC_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = '0;
`endif

endmodule

// File: tb/tb_nfc_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_nfc_cmd_sched
// Directed bench for nfc_cmd_sched: one N_REQ=4 instance (TIMEOUT_CYC=20) and
// one N_REQ=3 instance for the non-power-of-2 wrap. The watchdog section is
// compiled only when NFC_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_nfc_cmd_sched;
    import nfc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nfc_cmd_sched_if #(.N_REQ(4)) bus4 ();
    nfc_cmd_sched_if #(.N_REQ(3)) bus3 ();

    nfc_cmd_sched #(.N_REQ(4), .TIMEOUT_CYC(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    nfc_cmd_sched #(.N_REQ(3), .TIMEOUT_CYC(20)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    logic [CMD_W-1:0] cmd4 [4];
    logic [CMD_W-1:0] cmd3 [3];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle 1 time unit past the edge.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One complete command on the 4-requester DUT. Entry: an IDLE cycle.
    // lat = cycles from nfc_start to the nfc_done toggle.
    task automatic run4(input logic [3:0] valid, input logic [3:0] exp_gnt,
                        input int idx, input int lat, input bit keep, input string tag);
        bus4.req_valid = valid;
        #1;
        check({tag, " ready"}, bus4.req_ready, exp_gnt);
        step();
        if (!keep) bus4.req_valid = '0;
        check({tag, " start"}, bus4.nfc_start, 1);
        check({tag, " cmd"}, bus4.nfc_cmd, cmd4[idx]);
        check({tag, " busy_issue"}, bus4.busy, 1);
        check({tag, " ready_issue"}, bus4.req_ready, 0);
        step(lat);
        bus4.nfc_done = ~bus4.nfc_done;
        check({tag, " start_low"}, bus4.nfc_start, 0);
        check({tag, " cmd_stable"}, bus4.nfc_cmd, cmd4[idx]);
        check({tag, " no_early_rsp"}, bus4.rsp_done, 0);
        step();
        check({tag, " rsp_done"}, bus4.rsp_done, exp_gnt);
        check({tag, " rsp_err"}, bus4.rsp_err, 0);
        check({tag, " busy_resp"}, bus4.busy, 1);
        step();
        check({tag, " busy_low"}, bus4.busy, 0);
        check({tag, " rsp_clear"}, bus4.rsp_done, 0);
    endtask

    // One complete command on the 3-requester DUT.
    task automatic run3(input logic [2:0] valid, input logic [2:0] exp_gnt,
                        input int idx, input bit keep, input string tag);
        bus3.req_valid = valid;
        #1;
        check({tag, " ready"}, bus3.req_ready, exp_gnt);
        step();
        if (!keep) bus3.req_valid = '0;
        check({tag, " cmd"}, bus3.nfc_cmd, cmd3[idx]);
        step(3);
        bus3.nfc_done = ~bus3.nfc_done;
        step();
        check({tag, " rsp_done"}, bus3.rsp_done, exp_gnt);
        step();
    endtask

    initial begin
        cmd4[0] = 33'h0_1234_5601;
        cmd4[1] = 33'h1_0ABC_0F22;
        cmd4[2] = 33'h1_0000_4085;
        cmd4[3] = 33'h0_FFFF_C07F;
        cmd3[0] = 33'h0_0000_0A10;
        cmd3[1] = 33'h1_5555_2A2A;
        cmd3[2] = 33'h0_7E00_0003;

        rst            = 1'b1;
        bus4.req_valid = '0;
        bus4.nfc_done  = 1'b0;
        bus3.req_valid = '0;
        bus3.nfc_done  = 1'b0;
        for (int i = 0; i < 4; i++) bus4.req_cmd[CMD_W*i +: CMD_W] = cmd4[i];
        for (int i = 0; i < 3; i++) bus3.req_cmd[CMD_W*i +: CMD_W] = cmd3[i];

        // Reset values
        step(2);
        check("rst nfc_cmd", bus4.nfc_cmd, 0);
        check("rst nfc_start", bus4.nfc_start, 0);
        check("rst busy", bus4.busy, 0);
        check("rst rsp_done", bus4.rsp_done, 0);
        check("rst rsp_err", bus4.rsp_err, 0);
        check("rst req_ready", bus4.req_ready, 0);
        rst = 1'b0;
        step();

        // Single request, done toggles 0->1 nine cycles after start; ptr -> 3
        run4(4'b0100, 4'b0100, 2, 9, 1'b0, "single");

        // Second command completes on a 1->0 toggle; grant wraps 3->0; ptr -> 1
        run4(4'b0001, 4'b0001, 0, 4, 1'b0, "polarity");

        // Toggle while IDLE: must be discarded
        bus4.nfc_done = ~bus4.nfc_done;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_toggle rsp_done", bus4.rsp_done, 0);
            check("idle_toggle busy", bus4.busy, 0);
        end

        // Reset three cycles after nfc_start
        bus4.req_valid = 4'b1000;
        #1;
        check("abort ready", bus4.req_ready, 4'b1000);
        step();
        bus4.req_valid = '0;
        check("abort start", bus4.nfc_start, 1);
        step(3);
        rst           = 1'b1;
        bus4.nfc_done = 1'b0;   // NFC shares the reset, so its done level drops
        #1;
        check("abort nfc_cmd", bus4.nfc_cmd, 0);
        check("abort nfc_start", bus4.nfc_start, 0);
        check("abort busy", bus4.busy, 0);
        check("abort rsp_done", bus4.rsp_done, 0);
        check("abort req_ready", bus4.req_ready, 0);
        step(2);
        check("abort no_rsp", bus4.rsp_done, 0);
        rst = 1'b0;
        step();
        check("abort after rsp", bus4.rsp_done, 0);

        // Round-robin with every requester continuously valid; ptr back at 0
        run4(4'hF, 4'b0001, 0, 5, 1'b1, "rr0");
        run4(4'hF, 4'b0010, 1, 5, 1'b1, "rr1");
        run4(4'hF, 4'b0100, 2, 5, 1'b1, "rr2");
        run4(4'hF, 4'b1000, 3, 5, 1'b1, "rr3");
        run4(4'hF, 4'b0001, 0, 5, 1'b1, "rr4");
        bus4.req_valid = '0;
        step();
        check("rr idle", bus4.busy, 0);

        // N_REQ=3: push ptr to 2, then requesters 2 and 0 valid
        run3(3'b010, 3'b010, 1, 1'b0, "n3_first");
        run3(3'b101, 3'b100, 2, 1'b1, "n3_req2");
        run3(3'b101, 3'b001, 0, 1'b0, "n3_wrap0");

`ifdef NFC_TIMEOUT_EN
        // Watchdog expiry with no toggle: ptr=1 so requester 1 wins
        bus4.req_valid = 4'b0010;
        #1;
        check("wd ready", bus4.req_ready, 4'b0010);
        step();
        bus4.req_valid = '0;
        check("wd start", bus4.nfc_start, 1);
        step(20);
        check("wd not_yet", bus4.rsp_done, 0);
        step();
        check("wd rsp_done", bus4.rsp_done, 4'b0010);
        check("wd rsp_err", bus4.rsp_err, 4'b0010);
        step();
        check("wd busy_low", bus4.busy, 0);

        // Toggle coincident with expiry: done wins, no error; grant wraps from 2
        bus4.req_valid = 4'b0010;
        #1;
        check("wd2 ready", bus4.req_ready, 4'b0010);
        step();
        bus4.req_valid = '0;
        step(20);
        bus4.nfc_done = ~bus4.nfc_done;
        step();
        check("wd2 rsp_done", bus4.rsp_done, 4'b0010);
        check("wd2 rsp_err", bus4.rsp_err, 0);
        step();
        check("wd2 busy_low", bus4.busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
